// File: rtl/multi_channel_msg_queue_if.sv
// Handshake bundle for multi_channel_msg_queue: per-channel write ports,
// one registered read port, and per-channel occupancy/almost-full status.
//   master: producers/consumer side (drives wr_valid, wr_data, rd_ready)
//   slave : queue side (drives wr_ready, rd_*, level, almost_full)
interface multi_channel_msg_queue_if #(
    parameter int MSG_WIDTH  = 8,
    parameter int DEPTH_LOG2 = 3,
    parameter int NUM_CH     = 2
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int PW   = DEPTH_LOG2 + 1;

    logic [NUM_CH-1:0]           wr_valid;
    logic [NUM_CH*MSG_WIDTH-1:0] wr_data;
    logic [NUM_CH-1:0]           wr_ready;
    logic                        rd_valid;
    logic [MSG_WIDTH-1:0]        rd_data;
    logic [CH_W-1:0]             rd_ch;
    logic                        rd_ready;
    logic [NUM_CH*PW-1:0]        level;
    logic [NUM_CH-1:0]           almost_full;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_ch, level, almost_full
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_ch, level, almost_full
    );
endinterface

// File: rtl/multi_channel_msg_queue.sv
// NUM_CH circular FIFOs drained by an arbiter into one registered output.
// Ports: clock, reset_n (async active-low), bus (slave modport of
// multi_channel_msg_queue_if). Macro QUEUE_STRICT_PRIO_EN selects a
// fixed-priority arbiter (lowest index wins); default is round-robin.
module multi_channel_msg_queue #(
    parameter int MSG_WIDTH   = 8,
    parameter int DEPTH_LOG2  = 3,
    parameter int NUM_CH      = 2,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                     clock,
    input  logic                     reset_n,
    multi_channel_msg_queue_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int CH_W  = $clog2(NUM_CH);

    typedef logic [PW-1:0] ptr_t;

    ptr_t                 wr_ptr_q [NUM_CH];
    ptr_t                 wr_ptr_d [NUM_CH];
    ptr_t                 rd_ptr_q [NUM_CH];
    ptr_t                 rd_ptr_d [NUM_CH];
    logic [MSG_WIDTH-1:0] mem_q    [NUM_CH][DEPTH];

    logic                 rd_valid_q, rd_valid_d;
    logic [MSG_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [CH_W-1:0]      rd_ch_q, rd_ch_d;
`ifndef QUEUE_STRICT_PRIO_EN
    logic [CH_W-1:0]      last_grant_q, last_grant_d;
`endif

    ptr_t              lvl [NUM_CH];
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic              load;
    logic              gnt_found;
    logic [CH_W-1:0]   gnt_idx;

    // Wrap bit makes wr-rd a true occupancy count (0..DEPTH).
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign lvl[c]   = wr_ptr_q[c] - rd_ptr_q[c];
        assign full[c]  = (lvl[c] == ptr_t'(DEPTH));
        assign empty[c] = (lvl[c] == '0);
        assign push[c]  = bus.wr_valid[c] & ~full[c];
        assign bus.level[c*PW +: PW] = lvl[c];
        assign bus.almost_full[c]    = (lvl[c] >= ptr_t'(AFULL_LEVEL));
    end

    assign bus.wr_ready = ~full;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_ch    = rd_ch_q;

    assign load = ~rd_valid_q | bus.rd_ready;

    // Arbiter looks at pre-write occupancy, so a fresh write is never
    // visible on rd_* until one edge after it is accepted.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
`ifdef QUEUE_STRICT_PRIO_EN
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (!empty[c]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'(c);
            end
        end
`else
        // Scan backwards so the last hit is the nearest after last_grant.
        for (int i = NUM_CH; i >= 1; i--) begin
            if (!empty[(int'(last_grant_q) + i) % NUM_CH]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'((int'(last_grant_q) + i) % NUM_CH);
            end
        end
`endif
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_ch_d    = rd_ch_q;
`ifndef QUEUE_STRICT_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
                wr_ptr_d[c] = wr_ptr_q[c] + ptr_t'(1);
            end
        end
        if (load) begin
            rd_valid_d = gnt_found;
            if (gnt_found) begin
                rd_ptr_d[gnt_idx] = rd_ptr_q[gnt_idx] + ptr_t'(1);
                rd_data_d = mem_q[gnt_idx][rd_ptr_q[gnt_idx][DEPTH_LOG2-1:0]];
                rd_ch_d   = gnt_idx;
`ifndef QUEUE_STRICT_PRIO_EN
                last_grant_d = gnt_idx;
`endif
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ch_q    <= '0;
`ifndef QUEUE_STRICT_PRIO_EN
            last_grant_q <= CH_W'(NUM_CH - 1);
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ch_q    <= rd_ch_d;
`ifndef QUEUE_STRICT_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Storage holds no control state, so it is left unreset.
    always_ff @(posedge clock) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
                mem_q[c][wr_ptr_q[c][DEPTH_LOG2-1:0]] <=
                    bus.wr_data[c*MSG_WIDTH +: MSG_WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_multi_channel_msg_queue.sv
// Bench for multi_channel_msg_queue (NUM_CH=2, DEPTH_LOG2=2, AFULL_LEVEL=3):
// vector table, directed corner sequences, and random traffic vs a queue model.
module tb_multi_channel_msg_queue;
    localparam int MW = 8;
    localparam int DL = 2;
    localparam int NC = 2;
    localparam int AF = 3;
    localparam int DEPTH = 4;
    localparam int PW = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    multi_channel_msg_queue_if #(
        .MSG_WIDTH(MW), .DEPTH_LOG2(DL), .NUM_CH(NC)
    ) bus ();

    multi_channel_msg_queue #(
        .MSG_WIDTH(MW), .DEPTH_LOG2(DL), .NUM_CH(NC), .AFULL_LEVEL(AF)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    // Reference model: one queue per channel plus the output register.
    logic [7:0] mq [NC][$];
    bit         m_rv;
    logic [7:0] m_data;
    int         m_ch;
    int         m_lg;

    task automatic model_reset();
        for (int c = 0; c < NC; c++) mq[c].delete();
        m_rv = 0;
        m_data = 8'h00;
        m_ch = 0;
        m_lg = NC - 1;
    endtask

    task automatic model_edge();
        bit acc [NC];
        bit found;
        int g;
        for (int c = 0; c < NC; c++)
            acc[c] = bus.wr_valid[c] && (mq[c].size() < DEPTH);
        if (!m_rv || bus.rd_ready) begin
            found = 0;
            g = 0;
`ifdef QUEUE_STRICT_PRIO_EN
            for (int c = 0; c < NC; c++)
                if (!found && mq[c].size() > 0) begin found = 1; g = c; end
`else
            for (int i = 1; i <= NC; i++)
                if (!found && mq[(m_lg + i) % NC].size() > 0) begin
                    found = 1;
                    g = (m_lg + i) % NC;
                end
`endif
            if (found) begin
                m_data = mq[g].pop_front();
                m_ch = g;
                m_rv = 1;
                m_lg = g;
            end else begin
                m_rv = 0;
            end
        end
        for (int c = 0; c < NC; c++)
            if (acc[c]) mq[c].push_back(bus.wr_data[c*MW +: MW]);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_rv"}, 32'(bus.rd_valid), 32'(m_rv));
        if (m_rv) begin
            chk({tag, "_data"}, 32'(bus.rd_data), 32'(m_data));
            chk({tag, "_ch"}, 32'(bus.rd_ch), 32'(m_ch));
        end
        for (int c = 0; c < NC; c++) begin
            chk({tag, "_lvl"}, 32'(bus.level[c*PW +: PW]), 32'(mq[c].size()));
            chk({tag, "_wrdy"}, 32'(bus.wr_ready[c]),
                32'(mq[c].size() < DEPTH));
            chk({tag, "_af"}, 32'(bus.almost_full[c]),
                32'(mq[c].size() >= AF));
        end
    endtask

    task automatic set_in(input logic [1:0] wv, input logic [7:0] d0,
                          input logic [7:0] d1, input logic rr);
        bus.wr_valid = wv;
        bus.wr_data = {d1, d0};
        bus.rd_ready = rr;
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_in(2'b00, 8'h00, 8'h00, 1'b0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] wv;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rr;
        logic       erv;
        logic [7:0] edata;
        logic       ech;
        logic [2:0] el0;
        logic [2:0] el1;
        logic [1:0] ewr;
        logic [1:0] eaf;
    } vec_t;

    vec_t tv [14];
    logic [7:0] exp3 [6];
    logic [7:0] got4 [$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{2'b01, 8'hA5, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1, 3'd0, 2'b11, 2'b00};
        tv[1]  = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 3'd0, 3'd0, 2'b11, 2'b00};
        tv[2]  = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 2'b11, 2'b00};
        tv[3]  = '{2'b10, 8'h00, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 3'd1, 2'b11, 2'b00};
        tv[4]  = '{2'b10, 8'h00, 8'h11, 1'b0, 1'b1, 8'h10, 1'b1, 3'd0, 3'd1, 2'b11, 2'b00};
        tv[5]  = '{2'b10, 8'h00, 8'h12, 1'b0, 1'b1, 8'h10, 1'b1, 3'd0, 3'd2, 2'b11, 2'b00};
        tv[6]  = '{2'b10, 8'h00, 8'h13, 1'b0, 1'b1, 8'h10, 1'b1, 3'd0, 3'd3, 2'b11, 2'b10};
        tv[7]  = '{2'b10, 8'h00, 8'h14, 1'b0, 1'b1, 8'h10, 1'b1, 3'd0, 3'd4, 2'b01, 2'b10};
        tv[8]  = '{2'b10, 8'h00, 8'h15, 1'b0, 1'b1, 8'h10, 1'b1, 3'd0, 3'd4, 2'b01, 2'b10};
        tv[9]  = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h11, 1'b1, 3'd0, 3'd3, 2'b11, 2'b10};
        tv[10] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h12, 1'b1, 3'd0, 3'd2, 2'b11, 2'b00};
        tv[11] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h13, 1'b1, 3'd0, 3'd1, 2'b11, 2'b00};
        tv[12] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h14, 1'b1, 3'd0, 3'd0, 2'b11, 2'b00};
        tv[13] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 2'b11, 2'b00};
`ifdef QUEUE_STRICT_PRIO_EN
        exp3 = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12};
`else
        exp3 = '{8'h00, 8'h10, 8'h01, 8'h11, 8'h02, 8'h12};
`endif

        // Reset state
        do_reset();
        #1;
        chk("rst_rv", 32'(bus.rd_valid), 32'd0);
        chk("rst_data", 32'(bus.rd_data), 32'd0);
        chk("rst_ch", 32'(bus.rd_ch), 32'd0);
        chk("rst_lvl", 32'(bus.level), 32'd0);
        chk("rst_wrdy", 32'(bus.wr_ready), 32'h3);
        chk("rst_af", 32'(bus.almost_full), 32'd0);

        // Single message latency, then fill/backpressure/drain of ch1
        for (int i = 0; i < 14; i++) begin
            set_in(tv[i].wv, tv[i].d0, tv[i].d1, tv[i].rr);
            step();
            chk("vec_rv", 32'(bus.rd_valid), 32'(tv[i].erv));
            if (tv[i].erv) begin
                chk("vec_data", 32'(bus.rd_data), 32'(tv[i].edata));
                chk("vec_ch", 32'(bus.rd_ch), 32'(tv[i].ech));
            end
            chk("vec_lvl", 32'(bus.level), 32'({tv[i].el1, tv[i].el0}));
            chk("vec_wrdy", 32'(bus.wr_ready), 32'(tv[i].ewr));
            chk("vec_af", 32'(bus.almost_full), 32'(tv[i].eaf));
            check_model("vecm");
        end

        // Arbitration order across two preloaded channels
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(2'b11, 8'(i), 8'(8'h10 + i), 1'b0);
            step();
        end
        set_in(2'b00, 8'h00, 8'h00, 1'b1);
        for (int k = 0; k < 6; k++) begin
            chk("arb_rv", 32'(bus.rd_valid), 32'd1);
            chk("arb_data", 32'(bus.rd_data), 32'(exp3[k]));
            step();
            check_model("arbm");
        end
        chk("arb_end_rv", 32'(bus.rd_valid), 32'd0);

        // Streaming with wraparound
        do_reset();
        got4.delete();
        for (int i = 0; i < 13; i++) begin
            if (i < 10) set_in(2'b01, 8'(8'h20 + i), 8'h00, 1'b1);
            else set_in(2'b00, 8'h00, 8'h00, 1'b1);
            step();
            chk("strm_lvl_le1", 32'(bus.level[PW-1:0] <= 3'd1), 32'd1);
            if (bus.rd_valid) got4.push_back(bus.rd_data);
            check_model("strmm");
        end
        chk("strm_count", 32'(got4.size()), 32'd10);
        for (int i = 0; i < 10 && i < got4.size(); i++)
            chk("strm_order", 32'(got4[i]), 32'(8'h20 + i));

        // Output hold under backpressure
        do_reset();
        set_in(2'b01, 8'h33, 8'h00, 1'b0);
        step();
        set_in(2'b01, 8'h34, 8'h00, 1'b0);
        step();
        set_in(2'b00, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_rv", 32'(bus.rd_valid), 32'd1);
            chk("hold_data", 32'(bus.rd_data), 32'h33);
            chk("hold_ch", 32'(bus.rd_ch), 32'd0);
        end
        set_in(2'b00, 8'h00, 8'h00, 1'b1);
        step();
        chk("hold_next", 32'(bus.rd_data), 32'h34);
        check_model("holdm");

        // Async reset mid-cycle while full
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(2'b10, 8'h00, 8'(8'h40 + i), 1'b0);
            step();
        end
        set_in(2'b00, 8'h00, 8'h00, 1'b0);
        chk("arst_pre_wrdy", 32'(bus.wr_ready), 32'h1);
        chk("arst_pre_rv", 32'(bus.rd_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_rv", 32'(bus.rd_valid), 32'd0);
        chk("arst_lvl", 32'(bus.level), 32'd0);
        chk("arst_wrdy", 32'(bus.wr_ready), 32'h3);
        chk("arst_data", 32'(bus.rd_data), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Random traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            set_in(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                   (n < 300) ? ($urandom_range(0, 3) == 0)
                             : ($urandom_range(0, 3) != 0));
            step();
            check_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
